// File: rtl/dff_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_arbiter_pkg
//  Purpose  : FSM state encodings and the round-robin winner helper.
//  Revision : 1.0
// ============================================================================
package dff_bank_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam int c_MAX_REQ = 8;

   // One-hot winner: the first set request at or after ptr, wrapping modulo nreq.
   function automatic logic [c_MAX_REQ-1:0] rr_pick(
      input logic [c_MAX_REQ-1:0] req,
      input logic [2:0]           ptr,
      input int                   nreq
   );
      logic [c_MAX_REQ-1:0] oh;
      logic [2:0]           idx;
      logic                 found;
      oh    = '0;
      found = 1'b0;
      for (int k = 0; k < c_MAX_REQ; k++) begin
         idx = 3'((int'(ptr) + k) % nreq);
         if ((k < nreq) && !found && req[idx]) begin
            oh[idx] = 1'b1;
            found   = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dff_bank_arbiter_dff_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_reg
//  Purpose  : WIDTH-bit enabled register bank, synchronous reset to zero.
//  Revision : 1.0
// ============================================================================
module dff_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_arbiter
//  Purpose  : Round-robin arbiter granting one requester a one-cycle write
//             into a shared flip-flop bank, followed by a one-cycle ack.
//  Revision : 1.0
// ============================================================================
module dff_bank_arbiter
   import dff_bank_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic [WIDTH-1:0]        q
);

   localparam int OW = $clog2(NREQ);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [OW-1:0]          r_owner;
   logic [OW-1:0]          r_ptr;
   logic [c_MAX_REQ-1:0]   w_req8;
   logic [c_MAX_REQ-1:0]   w_win_oh;
   logic [OW-1:0]          w_win_idx;
   logic [OW-1:0]          w_ptr_nxt;
   logic [NREQ-1:0]        w_owner_oh;
   logic                   w_take;
   logic                   w_en;
   logic [WIDTH-1:0]       w_d;

   always_comb begin
      w_req8           = '0;
      w_req8[NREQ-1:0] = req;
      w_win_oh         = rr_pick(w_req8, 3'(r_ptr), NREQ);
      w_win_idx        = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win_oh[i]) begin
            w_win_idx = OW'(i);
         end
      end
      w_ptr_nxt = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + OW'(1);
   end

   // The unused code 2'd3 falls into default and recovers to IDLE.
   always_comb begin
      w_state_nxt = IDLE;
      w_take      = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_state_nxt = GRANT;
               w_take      = 1'b1;
            end
         end
         GRANT:   w_state_nxt = ACK;
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_owner <= w_win_idx;
            r_ptr   <= w_ptr_nxt;
         end
      end
   end

   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_owner_oh[i] = (int'(r_owner) == i);
      end
   end

   assign gnt   = (r_state == GRANT) ? w_owner_oh : '0;
   assign ack   = (r_state == ACK)   ? w_owner_oh : '0;
   assign busy  = (r_state == GRANT) || (r_state == ACK);
   assign owner = r_owner;
   assign w_en  = (r_state == GRANT);
   assign w_d   = wdata[int'(r_owner)*WIDTH +: WIDTH];

   dff_reg #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk (clk),
      .rst (rst),
      .en  (w_en),
      .d   (w_d),
      .q   (q)
   );

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_bank_arbiter
//  Purpose  : Directed self-checking bench with an ack-driven scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_dff_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [1:0]            owner;
   logic                  busy;
   logic [WIDTH-1:0]      q;

   typedef struct packed {
      logic [1:0]       idx;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en   = 1'b0;

   dff_bank_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .owner (owner),
      .busy  (busy),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input logic [WIDTH-1:0] d);
      exp_t e;
      e.idx  = 2'(idx);
      e.data = d;
      sb_q.push_back(e);
   endtask

   // Advance until a grant is visible (bounded); returns the cycles spent.
   task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp, output int cyc);
      cyc = 0;
      while (gnt == '0 && cyc < 12) begin
         tick();
         cyc++;
      end
      check(tag, 32'(gnt), 32'(exp));
   endtask

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mon_en && !rst && (|ack)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_ack",   32'(ack),   32'(1 << e.idx));
            check("sb_owner", 32'(owner), 32'(e.idx));
            check("sb_q",     32'(q),     32'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int order [3];
      rst   = 1'b1;
      req   = '0;
      wdata = '0;
      tick(); tick();
      rst    = 1'b0;
      mon_en = 1'b1;
      #4;
      check("rst_q",    32'(q),    32'h0);
      check("rst_gnt",  32'(gnt),  32'h0);
      check("rst_ack",  32'(ack),  32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_own",  32'(owner), 32'h0);

      // Single request from requester 2
      wdata[2*WIDTH +: WIDTH] = 8'hA5;
      req = 4'b0100;
      push(2, 8'hA5);
      tick();
      check("single_gnt",  32'(gnt),  32'h4);
      check("single_busy", 32'(busy), 32'h1);
      tick();
      check("single_q",   32'(q),   32'hA5);
      check("single_ack", 32'(ack), 32'h4);
      req = '0;
      tick();
      check("single_idle_busy", 32'(busy), 32'h0);

      // All four requesting from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
         push(i, 8'(8'h10 + i));
      end
      req = 4'b1111;
      wait_gnt("all_gnt0", 4'b0001, cyc);
      for (int i = 0; i < NREQ; i++) begin
         tick();
         check("all_q", 32'(q), 32'(8'h10 + i));
         req[i] = 1'b0;
         if (i < NREQ - 1) begin
            wait_gnt("all_gnt", 4'(1 << (i + 1)), cyc);
            check("all_spacing", 32'(cyc + 1), 32'd3);
         end
      end
      tick();

      // Fairness: requester 2 keeps its request while 1 and 3 join
      for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h20 + i);
      req = 4'b0100;
      push(2, 8'h22);
      wait_gnt("fair_gnt2", 4'b0100, cyc);
      tick();
      req[1] = 1'b1;
      req[3] = 1'b1;
      push(3, 8'h23);
      push(1, 8'h21);
      push(2, 8'h22);
      order = '{3, 1, 2};
      for (int k = 0; k < 3; k++) begin
         wait_gnt("fair_gnt", 4'(1 << order[k]), cyc);
         tick();
         req[order[k]] = 1'b0;
      end
      tick();

      // Reset asserted during GRANT abandons the write
      wdata[1*WIDTH +: WIDTH] = 8'hFF;
      req = 4'b0010;
      wait_gnt("rstg_gnt", 4'b0010, cyc);
      rst = 1'b1;
      tick();
      check("rstg_q",    32'(q),    32'h0);
      check("rstg_gnt",  32'(gnt),  32'h0);
      check("rstg_ack",  32'(ack),  32'h0);
      check("rstg_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      push(1, 8'hFF);
      wait_gnt("rstg_regnt", 4'b0010, cyc);
      tick();
      req = '0;
      tick();

      // Idle hold after writing 3C
      wdata[0*WIDTH +: WIDTH] = 8'h3C;
      req = 4'b0001;
      push(0, 8'h3C);
      wait_gnt("hold_gnt", 4'b0001, cyc);
      tick();
      req = '0;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("hold_q",    32'(q),    32'h3C);
         check("hold_gnt",  32'(gnt),  32'h0);
         check("hold_ack",  32'(ack),  32'h0);
         check("hold_busy", 32'(busy), 32'h0);
      end

      // Early drop of the request inside GRANT
      wdata[0*WIDTH +: WIDTH] = 8'h5A;
      req = 4'b0001;
      push(0, 8'h5A);
      wait_gnt("drop_gnt", 4'b0001, cyc);
      req = '0;
      tick();
      check("drop_ack", 32'(ack), 32'h1);
      check("drop_q",   32'(q),   32'h5A);
      tick(); tick();

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
